// File: rtl/uart_hex_formatter.sv
// uart_hex_formatter
//
// Streaming stage that sits directly in front of the UART byte emitter. It
// accepts one binary word and prints it as ASCII hex, most significant nibble
// first, followed by CR LF. Used for dumping counters and status words to the
// debug console.
//
// Build option:
//   HEX_PREFIX_EN - when defined, every word is preceded by "0x".
//
// Parameters:
//   DIGITS    - number of hex nibbles printed (1..8); word width is 4*DIGITS.
//   UPPERCASE - 0: a-f, 1: A-F.
//
// Ports:
//   i_clk        - clock
//   i_rst        - synchronous reset, active-high
//   i_word       - word to print, sampled only on the word handshake
//   i_word_valid - word request
//   o_word_ready - block idle, can take a word
//   o_data       - ASCII byte to the emitter
//   o_valid      - o_data valid
//   i_ready      - emitter ready to take the byte
//   o_state      - debug view of the current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once o_valid is raised it stays high, and o_data stays stable,
// until the emitter accepts the byte; the next character is loaded on the
// accepting edge, so a message goes out with no bubbles while i_ready is 1.

module uart_hex_formatter #(
    parameter int DIGITS    = 8,
    parameter bit UPPERCASE = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_word,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2:0]            o_state
);

    localparam int             W     = 4 * DIGITS;
    localparam int             KW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0]  K_TOP = KW'(DIGITS - 1);
    localparam logic [7:0]     ALPHA = UPPERCASE ? 8'h41 : 8'h61;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PFX0  = 3'd1,
        S_PFX1  = 3'd2,
        S_DIGIT = 3'd3,
        S_CR    = 3'd4,
        S_LF    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  word_q, word_d;
    logic [7:0]    data_d;
    logic          valid_d;
    logic          ready_d;
    logic [W-1:0]  shifted;
    logic [3:0]    nib;
    logic          word_accept;
    logic          byte_accept;

    assign word_accept = i_word_valid & o_word_ready;
    assign byte_accept = o_valid & i_ready;
    assign o_state     = state_q;

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            word_q       <= '0;
            o_data       <= 8'h00;
            o_valid      <= 1'b0;
            o_word_ready <= 1'b1;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            word_q       <= word_d;
            o_data       <= data_d;
            o_valid      <= valid_d;
            o_word_ready <= ready_d;
        end
    end

    // Next-state logic. Every non-idle state advances only on a byte handshake.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (word_accept) begin
                    word_d  = i_word;
                    k_d     = K_TOP;
`ifdef HEX_PREFIX_EN
                    state_d = S_PFX0;
`else
                    state_d = S_DIGIT;
`endif
                end
            end
`ifdef HEX_PREFIX_EN
            S_PFX0: if (byte_accept) state_d = S_PFX1;
            S_PFX1: if (byte_accept) state_d = S_DIGIT;
`endif
            S_DIGIT: begin
                if (byte_accept) begin
                    if (k_q == '0) state_d = S_CR;
                    else           k_d     = k_q - 1'b1;
                end
            end
            S_CR:    if (byte_accept) state_d = S_LF;
            S_LF:    if (byte_accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. The character is derived from the *next* state, index and
    // word so that it lands in o_data on the same edge the state moves. On the
    // word handshake word_d is i_word itself, giving the first digit one cycle
    // after the handshake.
    always_comb begin
        shifted = word_d >> {k_d, 2'b00};
        nib     = shifted[3:0];
        data_d  = o_data;
        case (state_d)
            S_PFX0:  data_d = 8'h30;
            S_PFX1:  data_d = 8'h78;
            S_DIGIT: data_d = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                                            : (ALPHA + {4'h0, nib} - 8'd10);
            S_CR:    data_d = 8'h0D;
            S_LF:    data_d = 8'h0A;
            default: data_d = o_data;
        endcase
        valid_d = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

endmodule
